pool2_requant: RTL

POOL2_REQUANT -- requirements
Module: pool2_requant

---
 rtl/pool2_requant.sv | 93 +++++++++
 1 files changed

// File: rtl/pool2_requant.sv
// pool2_requant: 2x2 max-pool over a raster stream of ReLU'd conv results,
// followed by logical right shift and saturation to the next layer's width.
module pool2_requant #(
    parameter int WIDTH = 8,
    parameter int IN_W  = WIDTH * 2 + $clog2(150),
    parameter int IMG_W = 10,
    parameter int IMG_H = 10,
    parameter int SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             frame_done
);
    localparam int HALF_W = IMG_W / 2;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam logic [IN_W-1:0] Q_MAX = IN_W'((64'd1 << (WIDTH - 1)) - 64'd1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [IN_W-1:0]  h_hold;
    logic [IN_W-1:0]  linebuf [HALF_W];
    logic             out_last;

    logic             accept;
    logic             col_last;
    logic             row_last;
    logic [IDX_W-1:0] pair_idx;
    logic [IN_W-1:0]  hmax;
    logic [IN_W-1:0]  pooled;
    logic [IN_W-1:0]  q;
    logic [WIDTH-1:0] q_sat;

    // Single output register: a new beat may enter whenever that register is free or draining.
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign col_last   = (col == COL_W'(IMG_W - 1));
    assign row_last   = (row == ROW_W'(IMG_H - 1));
    assign pair_idx   = IDX_W'(col >> 1);
    assign frame_done = out_valid && out_ready && out_last && !rst;

    always_comb begin
        hmax   = (in_data > h_hold) ? in_data : h_hold;
        pooled = (linebuf[pair_idx] > hmax) ? linebuf[pair_idx] : hmax;
        q      = pooled >> SHIFT;
        q_sat  = (q > Q_MAX) ? Q_MAX[WIDTH-1:0] : q[WIDTH-1:0];
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            h_hold    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                col <= col_last ? '0 : col + COL_W'(1);
                if (col_last) begin
                    row <= row_last ? '0 : row + ROW_W'(1);
                end
                if (!col[0]) begin
                    h_hold <= in_data;
                end else if (row[0]) begin
                    // Overrides the drain above, so a simultaneous handshake leaves no bubble.
                    out_valid <= 1'b1;
                    out_data  <= q_sat;
                    out_last  <= row_last && col_last;
                end
            end
        end
    end

    // NOTE: the line buffer has no reset; each even row rewrites every entry before the odd row reads it.
    always_ff @(posedge clk) begin
        if (!rst && accept && col[0] && !row[0]) begin
            linebuf[pair_idx] <= hmax;
        end
    end

endmodule
